// File: rtl/pe_net_pkg.sv
// Shared flit layout constants, FSM state types and hop-field helper for the
// PE network interface.
package pe_net_pkg;

  localparam int PAYLOAD_LSB = 10;
  localparam int PAYLOAD_W   = 5;
  localparam int SRC_W       = 4;
  localparam int HOP_W       = 3;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_REQ  = 2'd1,
    T_RTZ  = 2'd2
  } tx_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_ACK  = 1'b1
  } rx_state_t;

  // Returns {ydir, ymag[1:0], xdir, xmag[1:0]} for a route from node to dest.
  // Direction bit is set when the destination index is larger (east / north).
  function automatic logic [2*HOP_W-1:0] calc_hops(input int node, input int dest,
                                                   input int cols);
    int   srow, scol, drow, dcol, xmag, ymag;
    logic xdir, ydir;
    srow = node / cols;
    scol = node % cols;
    drow = dest / cols;
    dcol = dest % cols;
    xdir = (dcol > scol);
    ydir = (drow > srow);
    xmag = xdir ? (dcol - scol) : (scol - dcol);
    ymag = ydir ? (drow - srow) : (srow - drow);
    return {ydir, ymag[1:0], xdir, xmag[1:0]};
  endfunction

endpackage

// File: rtl/pe_net_rx_fifo.sv
// Small synchronous FIFO with occupancy count and a registered head word.
// Simultaneous push and pop are both honoured, including when full.
module pe_net_rx_fifo
  import pe_net_pkg::*;
#(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_wr,
  input  logic [W-1:0]               i_wdata,
  input  logic                       i_rd,
  output logic                       o_full,
  output logic                       o_valid,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic [W-1:0]               o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [W-1:0]  r_head;

  logic          w_full;
  logic          w_rd;
  logic          w_wr;
  logic [AW-1:0] w_rd_ptr_inc;

  assign w_full       = (r_count == CW'(DEPTH));
  assign w_rd         = i_rd & (r_count != '0);
  assign w_wr         = i_wr & (~w_full | w_rd);
  assign w_rd_ptr_inc = r_rd_ptr + AW'(1);

  // Storage array write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers, count and head register; the head bypasses the array when the
  // incoming word is about to become the oldest entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_wr && ((r_count == '0) || (w_rd && (r_count == CW'(1))))) begin
        r_head <= i_wdata;
      end else if (w_rd && (r_count > CW'(1))) begin
        r_head <= r_mem[w_rd_ptr_inc];
      end
    end
  end

  assign o_full  = w_full;
  assign o_valid = (r_count != '0);
  assign o_count = r_count;
  assign o_head  = r_head;

endmodule

// File: rtl/pe_net_iface.sv
// Network interface between a synchronous PE and its mesh router PE port.
// Tx: PE valid/ready -> routed flit -> 4-phase req/ack to router input.
// Rx: 4-phase req/ack from router output -> FIFO -> PE valid/ready.
// Self-addressed flits bypass the network and go straight into the rx FIFO.
module pe_net_iface
  import pe_net_pkg::*;
#(
  parameter int WIDTH       = 15,
  parameter int ROW         = 4,
  parameter int COL         = 4,
  parameter int NODE_NUM    = 0,
  parameter int X_HOP_LOC   = 4,
  parameter int Y_HOP_LOC   = 7,
  parameter int RX_DEPTH    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [SRC_W-1:0]     tx_dest,
  input  logic [PAYLOAD_W-1:0] tx_data,
  output logic                 net_out_req,
  input  logic                 net_out_ack,
  output logic [WIDTH-1:0]     net_out_data,
  input  logic                 net_in_req,
  output logic                 net_in_ack,
  input  logic [WIDTH-1:0]     net_in_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [SRC_W-1:0]     rx_src,
  output logic [PAYLOAD_W-1:0] rx_data
);

  localparam int FE_W = SRC_W + PAYLOAD_W;
  localparam int CW   = $clog2(RX_DEPTH) + 1;
  localparam logic [7:0] NODES = 8'(ROW * COL);

  tx_state_t r_tx_state;
  rx_state_t r_rx_state;

  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic [SYNC_STAGES-1:0] r_req_sync;
  logic                   r_out_req;
  logic [WIDTH-1:0]       r_out_data;
  logic                   r_in_ack;
  logic                   r_up;

  logic                   w_ack_s;
  logic                   w_req_s;
  logic                   w_self;
  logic                   w_pop;
  logic                   w_room;
  logic                   w_net_wr;
  logic                   w_tx_ready;
  logic                   w_tx_acc;
  logic                   w_lb_wr;
  logic                   w_fifo_wr;
  logic [FE_W-1:0]        w_fifo_wdata;
  logic                   w_fifo_full;
  logic                   w_fifo_valid;
  logic [CW-1:0]          w_fifo_count;
  logic [FE_W-1:0]        w_fifo_head;
  logic [2*HOP_W-1:0]     w_hops;
  logic [WIDTH-1:0]       w_flit;
  logic                   w_unused;

  // Synchronisers for the asynchronous handshake inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ack_sync <= '0;
      r_req_sync <= '0;
    end else begin
      r_ack_sync <= (r_ack_sync << 1) | SYNC_STAGES'(net_out_ack);
      r_req_sync <= (r_req_sync << 1) | SYNC_STAGES'(net_in_req);
    end
  end

  assign w_ack_s = r_ack_sync[SYNC_STAGES-1];
  assign w_req_s = r_req_sync[SYNC_STAGES-1];

  // A pop in the same cycle frees a slot, so it counts as room for a write.
  assign w_pop    = w_fifo_valid & rx_ready;
  assign w_room   = ~w_fifo_full | w_pop;
  assign w_net_wr = (r_rx_state == R_IDLE) & w_req_s & w_room;

  // Loopback needs the FIFO write port, which the network path wins.
  assign w_self     = (tx_dest == SRC_W'(NODE_NUM));
  assign w_tx_ready = r_up & (r_tx_state == T_IDLE) & (~w_self | (w_room & ~w_net_wr));
  assign w_tx_acc   = tx_valid & w_tx_ready;
  assign w_lb_wr    = w_tx_acc & w_self;

  assign w_fifo_wr    = w_net_wr | w_lb_wr;
  assign w_fifo_wdata = w_net_wr ? {net_in_data[SRC_W-1:0], net_in_data[PAYLOAD_LSB +: PAYLOAD_W]}
                                 : {SRC_W'(NODE_NUM), tx_data};

  assign w_hops = calc_hops(NODE_NUM, int'(tx_dest), COL);

  // Assemble the outgoing flit from payload, hop fields and source id.
  always_comb begin
    w_flit                            = '0;
    w_flit[PAYLOAD_LSB +: PAYLOAD_W]  = tx_data;
    w_flit[Y_HOP_LOC +: HOP_W]        = w_hops[HOP_W +: HOP_W];
    w_flit[X_HOP_LOC +: HOP_W]        = w_hops[0 +: HOP_W];
    w_flit[0 +: SRC_W]                = SRC_W'(NODE_NUM);
  end

  // Tx handshake: data and req launch together one cycle after accept and
  // data is held until the return-to-zero phase completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_state <= T_IDLE;
      r_out_req  <= 1'b0;
      r_out_data <= '0;
      r_up       <= 1'b0;
    end else begin
      r_up <= 1'b1;
      case (r_tx_state)
        T_IDLE: begin
          if (w_tx_acc && !w_self) begin
            r_out_data <= w_flit;
            r_out_req  <= 1'b1;
            r_tx_state <= T_REQ;
          end
        end
        T_REQ: begin
          if (w_ack_s) begin
            r_out_req  <= 1'b0;
            r_tx_state <= T_RTZ;
          end
        end
        T_RTZ: begin
          if (!w_ack_s) begin
            r_tx_state <= T_IDLE;
          end
        end
        default: r_tx_state <= T_IDLE;
      endcase
    end
  end

  // Rx handshake: capture on synced req when there is room; a full FIFO
  // withholds ack, which backpressures the router.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_state <= R_IDLE;
      r_in_ack   <= 1'b0;
    end else begin
      case (r_rx_state)
        R_IDLE: begin
          if (w_net_wr) begin
            r_in_ack   <= 1'b1;
            r_rx_state <= R_ACK;
          end
        end
        R_ACK: begin
          if (!w_req_s) begin
            r_in_ack   <= 1'b0;
            r_rx_state <= R_IDLE;
          end
        end
        default: r_rx_state <= R_IDLE;
      endcase
    end
  end

  pe_net_rx_fifo #(
    .W     (FE_W),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wr    (w_fifo_wr),
    .i_wdata (w_fifo_wdata),
    .i_rd    (w_pop),
    .o_full  (w_fifo_full),
    .o_valid (w_fifo_valid),
    .o_count (w_fifo_count),
    .o_head  (w_fifo_head)
  );

  // Hop bits of received flits, the occupancy count and the mesh size are
  // not needed on the PE side.
  assign w_unused = ^{net_in_data[PAYLOAD_LSB-1:SRC_W], w_fifo_count, NODES};

  assign tx_ready     = w_tx_ready;
  assign net_out_req  = r_out_req;
  assign net_out_data = r_out_data;
  assign net_in_ack   = r_in_ack;
  assign rx_valid     = w_fifo_valid;
  assign rx_src       = w_fifo_head[PAYLOAD_W +: SRC_W];
  assign rx_data      = w_fifo_head[0 +: PAYLOAD_W];

endmodule

// File: tb/tb_pe_net_iface.sv
// Self-checking bench for pe_net_iface at node 5 of a 4x4 mesh. The bench
// plays the router on both handshakes and keeps a queue of expected rx words.
module tb_pe_net_iface;

  localparam int NODE = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tx_valid;
  logic        tx_ready;
  logic [3:0]  tx_dest;
  logic [4:0]  tx_data;
  logic        net_out_req;
  logic        net_out_ack;
  logic [14:0] net_out_data;
  logic        net_in_req;
  logic        net_in_ack;
  logic [14:0] net_in_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [3:0]  rx_src;
  logic [4:0]  rx_data;

  int n_cmp = 0;
  int n_err = 0;
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];

  always #5 clk = ~clk;

  pe_net_iface #(
    .WIDTH(15), .ROW(4), .COL(4), .NODE_NUM(NODE),
    .X_HOP_LOC(4), .Y_HOP_LOC(7), .RX_DEPTH(4), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dest(tx_dest), .tx_data(tx_data),
    .net_out_req(net_out_req), .net_out_ack(net_out_ack), .net_out_data(net_out_data),
    .net_in_req(net_in_req), .net_in_ack(net_in_ack), .net_in_data(net_in_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_src(rx_src), .rx_data(rx_data)
  );

  // Reference flit: payload*1024 + yfield*128 + xfield*16 + src.
  function automatic logic [14:0] model_flit(input int node, input int dest, input int data);
    int sr, sc, dr, dc, xf, yf;
    sr = node / 4;  sc = node % 4;
    dr = dest / 4;  dc = dest % 4;
    xf = (dc > sc) ? 4 + (dc - sc) : (sc - dc);
    yf = (dr > sr) ? 4 + (dr - sr) : (sr - dr);
    return 15'(data * 1024 + yf * 128 + xf * 16 + node);
  endfunction

  // What the PE should see for a received flit: {src, payload}.
  function automatic logic [8:0] model_entry(input logic [14:0] f);
    int v;
    v = int'(f);
    return 9'(((v % 16) * 32) + (v / 1024));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_in_ack(input logic level, input int bound, output int lat);
    lat = -1;
    for (int i = 0; i < bound; i++) begin
      if (net_in_ack === level) begin
        lat = i;
        return;
      end
      tick();
    end
  endtask

  // Router side of one tx handshake, assuming the flit was just accepted.
  task automatic router_tx(output logic [14:0] d_req, output logic [14:0] d_rtz,
                           output bit ok, output bit rdy_seen);
    int  i;
    ok = 1'b0; rdy_seen = 1'b0; d_req = 'x; d_rtz = 'x;
    for (i = 0; i < 20 && net_out_req !== 1'b1; i++) tick();
    if (net_out_req !== 1'b1) return;
    d_req = net_out_data;
    repeat ($urandom_range(0, 2)) begin
      if (tx_ready) rdy_seen = 1'b1;
      tick();
    end
    net_out_ack = 1'b1;
    for (i = 0; i < 20 && net_out_req !== 1'b0; i++) begin
      if (tx_ready) rdy_seen = 1'b1;
      tick();
    end
    if (net_out_req !== 1'b0) begin
      net_out_ack = 1'b0;
      return;
    end
    d_rtz = net_out_data;
    net_out_ack = 1'b0;
    for (i = 0; i < 20 && tx_ready !== 1'b1; i++) tick();
    ok = (tx_ready === 1'b1);
  endtask

  // Pops everything currently queued into got_q (bounded).
  task automatic drain(input int expected);
    got_q.delete();
    rx_ready = 1'b1;
    for (int i = 0; i < 40 && got_q.size() < expected; i++) begin
      if (rx_valid) got_q.push_back({rx_src, rx_data});
      tick();
    end
    rx_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tx_valid = 1'b0; tx_dest = 4'd0; tx_data = 5'd0;
    net_out_ack = 1'b0; net_in_req = 1'b0; net_in_data = '0; rx_ready = 1'b0;
    repeat (3) tick();
    n_cmp++; if (tx_ready !== 1'b0) begin n_err++; $display("FAIL rst_tx_ready: got %b want 0", tx_ready); end
    n_cmp++; if (net_out_req !== 1'b0) begin n_err++; $display("FAIL rst_out_req: got %b want 0", net_out_req); end
    n_cmp++; if (net_out_data !== 15'h0) begin n_err++; $display("FAIL rst_out_data: got %h want 0", net_out_data); end
    n_cmp++; if (net_in_ack !== 1'b0) begin n_err++; $display("FAIL rst_in_ack: got %b want 0", net_in_ack); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL rst_rx_valid: got %b want 0", rx_valid); end
    n_cmp++; if ({rx_src, rx_data} !== 9'h0) begin n_err++; $display("FAIL rst_rx_head: got %h want 0", {rx_src, rx_data}); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b want 1", tx_ready); end
    $display("reset done");
  endtask

  task automatic test_tx_directed();
    int          dests [2];
    int          datas [2];
    logic [14:0] exps  [2];
    logic [14:0] d_req, d_rtz;
    bit          ok, rdy;
    dests = '{15, 0};
    datas = '{26, 0};
    exps  = '{15'h6B65, 15'h0095};
    for (int i = 0; i < 2; i++) begin
      tx_valid = 1'b1; tx_dest = 4'(dests[i]); tx_data = 5'(datas[i]);
      #1;
      n_cmp++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL txd_accept_ready[%0d]: got %b want 1", i, tx_ready); end
      n_cmp++; if (net_out_req !== 1'b0) begin n_err++; $display("FAIL txd_req_at_accept[%0d]: got %b want 0", i, net_out_req); end
      tick();
      tx_valid = 1'b0;
      n_cmp++; if (net_out_req !== 1'b1) begin n_err++; $display("FAIL txd_req_rise[%0d]: got %b want 1", i, net_out_req); end
      router_tx(d_req, d_rtz, ok, rdy);
      n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL txd_handshake[%0d]: got %b want 1", i, ok); end
      n_cmp++; if (d_req !== exps[i]) begin n_err++; $display("FAIL txd_flit[%0d]: got %h want %h", i, d_req, exps[i]); end
      n_cmp++; if (d_rtz !== exps[i]) begin n_err++; $display("FAIL txd_flit_held[%0d]: got %h want %h", i, d_rtz, exps[i]); end
      n_cmp++; if (rdy !== 1'b0) begin n_err++; $display("FAIL txd_ready_busy[%0d]: got %b want 0", i, rdy); end
      n_cmp++; if (net_out_req !== 1'b0) begin n_err++; $display("FAIL txd_req_fall[%0d]: got %b want 0", i, net_out_req); end
      $display("tx dest=%0d data=%h flit=%h", dests[i], datas[i], d_req);
    end
  endtask

  task automatic test_tx_random();
    logic [14:0] d_req, d_rtz, exp_f;
    bit          ok, rdy;
    int          dest, data;
    for (int i = 0; i < 8; i++) begin
      dest = int'($urandom_range(0, 15));
      if (dest == NODE) dest = 6;
      data = int'($urandom_range(0, 31));
      exp_f = model_flit(NODE, dest, data);
      tx_valid = 1'b1; tx_dest = 4'(dest); tx_data = 5'(data);
      #1;
      n_cmp++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL txr_accept_ready[%0d]: got %b want 1", i, tx_ready); end
      tick();
      tx_valid = 1'b0;
      router_tx(d_req, d_rtz, ok, rdy);
      n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL txr_handshake[%0d]: got %b want 1", i, ok); end
      n_cmp++; if (d_req !== exp_f) begin n_err++; $display("FAIL txr_flit[%0d]: got %h want %h", i, d_req, exp_f); end
      $display("tx dest=%0d data=%h flit=%h", dest, data, d_req);
    end
  endtask

  task automatic test_rx_basic();
    int lat;
    net_in_data = 15'h6B65;
    net_in_req = 1'b1;
    wait_in_ack(1'b1, 10, lat);
    n_cmp++; if (lat != 3) begin n_err++; $display("FAIL rx_ack_latency: got %0d want 3", lat); end
    tick();
    n_cmp++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL rx_valid: got %b want 1", rx_valid); end
    n_cmp++; if (rx_src !== 4'd5) begin n_err++; $display("FAIL rx_src: got %h want 5", rx_src); end
    n_cmp++; if (rx_data !== 5'h1A) begin n_err++; $display("FAIL rx_data: got %h want 1a", rx_data); end
    net_in_req = 1'b0;
    wait_in_ack(1'b0, 10, lat);
    n_cmp++; if (lat < 0) begin n_err++; $display("FAIL rx_ack_fall: got timeout want ack low"); end
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    #1;
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL rx_empty_after_pop: got %b want 0", rx_valid); end
    $display("rx flit=6b65 src=%h data=%h", 4'd5, 5'h1A);
  endtask

  task automatic test_backpressure();
    logic [14:0] f;
    int          lat, lat2;
    exp_q.delete();
    rx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      f = 15'($urandom);
      exp_q.push_back(model_entry(f));
      net_in_data = f; net_in_req = 1'b1;
      wait_in_ack(1'b1, 20, lat);
      net_in_req = 1'b0;
      wait_in_ack(1'b0, 20, lat2);
      n_cmp++; if (lat < 0 || lat2 < 0) begin n_err++; $display("FAIL bp_fill[%0d]: got lat %0d/%0d want >=0", i, lat, lat2); end
      $display("rx fill flit=%h", f);
    end
    tx_valid = 1'b1; tx_dest = 4'(NODE); tx_data = 5'h07;
    #1;
    n_cmp++; if (tx_ready !== 1'b0) begin n_err++; $display("FAIL bp_loopback_full: got %b want 0", tx_ready); end
    tx_valid = 1'b0; tx_dest = 4'd0;
    f = 15'($urandom);
    net_in_data = f; net_in_req = 1'b1;
    wait_in_ack(1'b1, 12, lat);
    n_cmp++; if (lat != -1) begin n_err++; $display("FAIL bp_ack_withheld: got lat %0d want timeout", lat); end
    rx_ready = 1'b1;
    #1;
    n_cmp++; if ({rx_src, rx_data} !== exp_q[0]) begin n_err++; $display("FAIL bp_pop_head: got %h want %h", {rx_src, rx_data}, exp_q[0]); end
    void'(exp_q.pop_front());
    tick();
    rx_ready = 1'b0;
    exp_q.push_back(model_entry(f));
    wait_in_ack(1'b1, 10, lat);
    n_cmp++; if (lat < 0) begin n_err++; $display("FAIL bp_ack_after_pop: got timeout want ack"); end
    net_in_req = 1'b0;
    wait_in_ack(1'b0, 10, lat);
    drain(4);
    n_cmp++; if (got_q.size() != 4) begin n_err++; $display("FAIL bp_drain_count: got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL bp_order[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b want 0", rx_valid); end
    exp_q.delete();
    $display("backpressure sequence done");
  endtask

  task automatic test_loopback_collision();
    logic [14:0] f;
    logic [4:0]  d;
    int          lat;
    bit          req_seen;
    exp_q.delete();
    f = 15'($urandom);
    d = 5'($urandom);
    exp_q.push_back(model_entry(f));
    net_in_data = f; net_in_req = 1'b1;
    tick();
    tick();
    tx_valid = 1'b1; tx_dest = 4'(NODE); tx_data = d;
    #1;
    n_cmp++; if (tx_ready !== 1'b0) begin n_err++; $display("FAIL lb_collision_blocked: got %b want 0", tx_ready); end
    tick();
    n_cmp++; if (net_in_ack !== 1'b1) begin n_err++; $display("FAIL lb_net_write_won: got %b want 1", net_in_ack); end
    n_cmp++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL lb_ready_next: got %b want 1", tx_ready); end
    tick();
    tx_valid = 1'b0; tx_dest = 4'd0;
    exp_q.push_back({4'(NODE), d});
    req_seen = (net_out_req !== 1'b0);
    net_in_req = 1'b0;
    wait_in_ack(1'b0, 10, lat);
    drain(2);
    req_seen = req_seen | (net_out_req !== 1'b0);
    n_cmp++; if (req_seen) begin n_err++; $display("FAIL lb_no_inject: got req high want 0"); end
    n_cmp++; if (got_q.size() != 2) begin n_err++; $display("FAIL lb_count: got %0d want 2", got_q.size()); end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL lb_order[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete();
    $display("loopback data=%h behind net flit=%h", d, f);
  endtask

  task automatic test_rx_random();
    exp_q.delete();
    fork
      begin : sender
        logic [14:0] f;
        int          lat;
        for (int i = 0; i < 12; i++) begin
          f = 15'($urandom);
          exp_q.push_back(model_entry(f));
          net_in_data = f; net_in_req = 1'b1;
          wait_in_ack(1'b1, 200, lat);
          n_cmp++; if (lat < 0) begin n_err++; $display("FAIL rr_ack[%0d]: got timeout want ack", i); end
          net_in_req = 1'b0;
          wait_in_ack(1'b0, 20, lat);
          repeat ($urandom_range(0, 2)) tick();
        end
      end
      begin : popper
        int         got;
        logic [8:0] want;
        got = 0;
        for (int c = 0; c < 3000 && got < 12; c++) begin
          rx_ready = 1'($urandom_range(0, 1));
          #1;
          if (rx_valid && rx_ready) begin
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 9'bx;
            n_cmp++;
            if ({rx_src, rx_data} !== want) begin
              n_err++; $display("FAIL rr_data[%0d]: got %h want %h", got, {rx_src, rx_data}, want);
            end
            $display("rx pop %0d src=%h data=%h", got, rx_src, rx_data);
            got++;
          end
          @(posedge clk);
          #1;
        end
        rx_ready = 1'b0;
        n_cmp++; if (got != 12) begin n_err++; $display("FAIL rr_count: got %0d want 12", got); end
      end
    join
  endtask

  task automatic test_reset_mid();
    int lat;
    tx_valid = 1'b1; tx_dest = 4'd12; tx_data = 5'($urandom);
    #1;
    tick();
    tx_valid = 1'b0; tx_dest = 4'd0;
    net_in_data = 15'($urandom); net_in_req = 1'b1;
    wait_in_ack(1'b1, 10, lat);
    n_cmp++; if (net_out_req !== 1'b1 || rx_valid !== 1'b1) begin n_err++; $display("FAIL rm_setup: got req %b valid %b want 1 1", net_out_req, rx_valid); end
    rst_n = 1'b0;
    tick();
    n_cmp++; if (net_out_req !== 1'b0) begin n_err++; $display("FAIL rm_out_req: got %b want 0", net_out_req); end
    n_cmp++; if (net_in_ack !== 1'b0) begin n_err++; $display("FAIL rm_in_ack: got %b want 0", net_in_ack); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL rm_rx_valid: got %b want 0", rx_valid); end
    n_cmp++; if (tx_ready !== 1'b0) begin n_err++; $display("FAIL rm_tx_ready: got %b want 0", tx_ready); end
    net_in_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL rm_ready_after: got %b want 1", tx_ready); end
    $display("mid-handshake reset done");
  endtask

  initial begin
    test_reset();
    test_tx_directed();
    test_tx_random();
    test_rx_basic();
    test_backpressure();
    test_loopback_collision();
    test_rx_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
